// File: rtl/carry_select_adder_pkg.sv
// Shared sizing constants for the carry-select adder and its ripple blocks.
package carry_select_adder_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_BLOCK      = 4;
  localparam int unsigned DEF_NUM_BLOCKS = DEF_WIDTH / DEF_BLOCK;

  function automatic int unsigned num_blocks(input int unsigned width, input int unsigned block);
    return width / block;
  endfunction

endpackage

// File: rtl/carry_select_adder_ripple_block.sv
// csel_ripple_block: BLOCK-bit ripple-carry adder; msb_ci exposes the carry into the top bit.
module csel_ripple_block #(
  parameter int unsigned BLOCK = carry_select_adder_pkg::DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             msb_ci
);

  logic [BLOCK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co     = c[BLOCK];
  assign msb_ci = c[BLOCK-1];

endmodule

// File: rtl/carry_select_adder.sv
// Registered two's-complement adder with carry-in, built from carry-select blocks;
// produces sum, unsigned carry-out and signed overflow one clock after sampling.
module carry_select_adder
  import carry_select_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of
);

  localparam int unsigned NUM_BLOCKS = num_blocks(WIDTH, BLOCK);

  logic [NUM_BLOCKS:0] blk_c;
  logic [WIDTH-1:0]    sum_c;
  logic                msb_c;
  logic                of_c;

  assign blk_c[0] = cin;

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
    if (k == 0) begin : g_first
      logic m0;
      csel_ripple_block #(.BLOCK(BLOCK)) u_rca (
        .a      (A[k*BLOCK +: BLOCK]),
        .b      (B[k*BLOCK +: BLOCK]),
        .ci     (blk_c[0]),
        .s      (sum_c[k*BLOCK +: BLOCK]),
        .co     (blk_c[1]),
        .msb_ci (m0)
      );
      if (NUM_BLOCKS == 1) begin : g_msb
        assign msb_c = m0;
      end
    end else begin : g_sel
      logic [BLOCK-1:0] s0, s1;
      logic             co0, co1, m0, m1;
      csel_ripple_block #(.BLOCK(BLOCK)) u_rca0 (
        .a      (A[k*BLOCK +: BLOCK]),
        .b      (B[k*BLOCK +: BLOCK]),
        .ci     (1'b0),
        .s      (s0),
        .co     (co0),
        .msb_ci (m0)
      );
      csel_ripple_block #(.BLOCK(BLOCK)) u_rca1 (
        .a      (A[k*BLOCK +: BLOCK]),
        .b      (B[k*BLOCK +: BLOCK]),
        .ci     (1'b1),
        .s      (s1),
        .co     (co1),
        .msb_ci (m1)
      );
      // Incoming block carry picks the precomputed slice and outgoing carry.
      assign sum_c[k*BLOCK +: BLOCK] = blk_c[k] ? s1  : s0;
      assign blk_c[k+1]              = blk_c[k] ? co1 : co0;
      if (k == NUM_BLOCKS - 1) begin : g_msb
        assign msb_c = blk_c[k] ? m1 : m0;
      end
    end
  end

  assign of_c = msb_c ^ blk_c[NUM_BLOCKS];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      of   <= 1'b0;
    end else begin
      sum  <= sum_c;
      cout <= blk_c[NUM_BLOCKS];
      of   <= of_c;
    end
  end

endmodule

// File: tb/tb_carry_select_adder.sv
// Scoreboard bench for carry_select_adder: driver queues expected results from an
// arithmetic reference model; a monitor pops and compares after every clock edge.
module tb_carry_select_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B, sum;
  logic        cin, cout, of;

  typedef struct packed {
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
  } stim_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        of;
  } resp_t;

  stim_t stim_q[$];
  resp_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  carry_select_adder #(.WIDTH(32), .BLOCK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .of   (of)
  );

  always #5 clk = ~clk;

  function automatic resp_t model(input stim_t s);
    resp_t           r;
    longint unsigned u;
    longint          sr;
    r = '0;
    if (!s.rst) begin
      u      = longint'(s.a) + longint'(s.b) + longint'(s.cin);
      r.sum  = u[31:0];
      r.cout = u[32];
      sr     = longint'($signed(s.a)) + longint'($signed(s.b)) + longint'(s.cin);
      r.of   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end
    return r;
  endfunction

  task automatic add_vec(input logic r, input logic [31:0] a, input logic [31:0] b, input logic c);
    stim_t s;
    s.rst = r; s.a = a; s.b = b; s.cin = c;
    stim_q.push_back(s);
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst;
    A   = s.a;
    B   = s.b;
    cin = s.cin;
    exp_q.push_back(model(s));
  endtask

  // Monitor: the edge just passed captured the oldest queued stimulus.
  initial begin
    resp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = '{sum: sum, cout: cout, of: of};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL result: got sum=%h cout=%b of=%b, expected sum=%h cout=%b of=%b",
                   g.sum, g.cout, g.of, e.sum, e.cout, e.of);
        end
      end
    end
  end

  initial begin
    add_vec(1'b1, $urandom, $urandom, 1'b1);
    add_vec(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    add_vec(1'b0, 32'd5, 32'd7, 1'b1);
    add_vec(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    add_vec(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    add_vec(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    add_vec(1'b0, 32'h0000_0001, 32'h8000_0000, 1'b0);
    add_vec(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    add_vec(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
    add_vec(1'b0, 32'h0000_FFFF, 32'h00FF_0000, 1'b0);
    add_vec(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    add_vec(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    add_vec(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    add_vec(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    add_vec(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    add_vec(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add_vec(1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    for (int i = 0; i < 300; i++) begin
      add_vec(($urandom_range(0, 19) == 0), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    apply(stim_q.pop_front());
    while (stim_q.size() != 0) begin
      @(posedge clk);
      #2;
      apply(stim_q.pop_front());
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carry_select_adder.md
# carry_select_adder

Registered 32-bit two's-complement adder with carry-in, built as a carry-select structure. It produces the sum, the unsigned carry-out and the signed-overflow flag. Outputs update one clock after the operands are sampled. It is one of the interchangeable adder implementations in the adder comparison set, so its port semantics match the other adders.

## Interface
Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLOCK.
- BLOCK, 4, bits per carry-select block.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- A  input  WIDTH  operand A (two's complement).
- B  input  WIDTH  operand B (two's complement).
- cin  input  1  carry-in, added at bit 0.
- sum  output  WIDTH  registered (A + B + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- of  output  1  registered signed overflow.

## Operation
- Full result: {cout, sum} = A + B + cin, computed as unsigned (WIDTH+1)-bit arithmetic.
- Overflow: of = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]).
  - Equivalently, of = carry into MSB XOR carry out of MSB.
  - of is independent of cout. Example: -1 + -2^31 gives cout=1 and of=1; -1 + -1 gives cout=1 and of=0.
- Datapath is divided into WIDTH/BLOCK blocks:
  - Block 0 is a BLOCK-bit ripple adder fed by cin.
  - Each block k≥1 holds two BLOCK-bit ripple adders, one with carry-in 0 and one with carry-in 1.
  - Block k's carry-out from block k-1 selects between the two sum slices and between the two block carry-outs.
  - The selected carry of the last block is cout.
- The carry into the MSB is taken from the internal ripple of the selected last-block adder.
- No enable: operands are sampled every cycle. X-free inputs give X-free outputs.

## Timing
- Combinational datapath from A/B/cin to the register D inputs; the output registers are sum, cout and of.
- Latency 1 cycle: operands present before rising edge k appear on the outputs after edge k. Throughput is one result per cycle.
- Reset:
  - rst=1 at an edge sets sum=0, cout=0, of=0.
  - Reset has priority over new operands.
  - If reset is asserted mid-stream, the result in flight is discarded. The first edge with rst=0 captures the current operands.
- Operand changes between edges have no effect on the outputs until the next edge.
- Wrap-around: results beyond 2^WIDTH-1 wrap modulo 2^WIDTH, and the excess appears on cout. No saturation.
- Simultaneous cin=1 with all-ones operands: A=B=0xFFFFFFFF, cin=1 gives sum=0xFFFFFFFF, cout=1, of=0.

## Structure
- Shared package: WIDTH/BLOCK default constants and the derived NUM_BLOCKS = WIDTH/BLOCK.
- One sub-module: csel_ripple_block, a BLOCK-bit ripple-carry adder with ports a, b, ci, s, co and msb_ci (carry into the block's top bit).
  - Instantiated once for block 0 and twice for each later block.
- Top level: generate loop of blocks plus selection muxes, overflow logic and the output register stage.

## Test plan
- Positive overflow: A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum=0x80000000, cout=0, of=1.
- Negative overflow: A=0xFFFFFFFF, B=0x80000000, cin=0 -> sum=0x7FFFFFFF, cout=1, of=1.
- Mixed signs, no overflow:
  - A=0x7FFFFFFF, B=0xFFFFFFFF -> sum=0x7FFFFFFE, cout=1, of=0.
  - A=0x00000001, B=0x80000000 -> sum=0x80000001, cout=0, of=0.
- Carry propagation across blocks:
  - A=0xFFFFFFFF, B=0x00000001 -> sum=0, cout=1, of=0.
  - A=B=0x0000FFFF -> sum=0x0001FFFE, cout=0, of=0.
  - A=0x0000FFFF, B=0x00FF0000 -> sum=0x00FFFFFF, cout=0.
  - A=B=0xFFFFFFFF -> sum=0xFFFFFFFE, cout=1.
- Reset and latency:
  - Hold rst=1 with any operands -> outputs 0.
  - Deassert rst and apply A=5, B=7, cin=1 -> sum=13 one edge later, never earlier.
  - Assert rst mid-stream -> outputs 0 at the next edge.
  - Random back-to-back operands checked against the A+B+cin reference model each cycle.
